// File: rtl/result_out_stage_pkg.sv
// Shared types for the arithmetic result output stage: skid buffer states,
// per-entry status flags and default widths.
package arith_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic negative;
    logic zero;
    logic overflow;
    logic error;
  } arith_status_t;

  localparam int ARITH_BITS     = 32;
  localparam int ARITH_CNT_BITS = 8;

  // An errored result carries no meaningful data, so every other flag is forced low.
  function automatic arith_status_t capture_status(input logic msb,
                                                   input logic is_zero,
                                                   input logic ovf,
                                                   input logic err);
    arith_status_t st;
    if (err) begin
      st = '{negative: 1'b0, zero: 1'b0, overflow: 1'b0, error: 1'b1};
    end else begin
      st = '{negative: msb, zero: is_zero, overflow: ovf, error: 1'b0};
    end
    return st;
  endfunction

endpackage

// File: rtl/result_out_stage_if.sv
// Upstream and downstream handshake bundle of the output stage, named from the
// stage's point of view. Handshake: a beat transfers on a rising edge where
// valid and ready are both high; a source holding valid keeps its payload stable.
interface result_out_stage_if #(parameter int BITS = arith_pkg::ARITH_BITS);

  logic            i_valid;
  logic            o_ready;
  logic [BITS-1:0] i_result;
  logic            i_error;
  logic            i_overflow;

  logic            o_valid;
  logic            i_ready;
  logic [BITS-1:0] o_result;
  logic            o_error;
  logic            o_overflow;
  logic            o_zero;
  logic            o_negative;

  modport slave (
    input  i_valid, i_result, i_error, i_overflow, i_ready,
    output o_ready, o_valid, o_result, o_error, o_overflow, o_zero, o_negative
  );

  modport master (
    output i_valid, i_result, i_error, i_overflow, i_ready,
    input  o_ready, o_valid, o_result, o_error, o_overflow, o_zero, o_negative
  );

endinterface

// File: rtl/result_out_stage_sat_counter.sv
// Saturating event counter; a clear request wins over a same-cycle increment.
module sat_counter #(
  parameter int CNT_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_inc,
  input  logic                i_clr,
  output logic [CNT_BITS-1:0] o_cnt
);

  logic [CNT_BITS-1:0] cnt_q;
  logic [CNT_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_cnt = cnt_q;

endmodule

// File: rtl/result_out_stage.sv
// Registered 2-entry skid buffer behind the shift unit: captures result and
// flags at push time, presents them from the head entry, counts error/overflow events.
module result_out_stage
  import arith_pkg::*;
#(
  parameter int BITS     = ARITH_BITS,
  parameter int CNT_BITS = ARITH_CNT_BITS
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  result_out_stage_if.slave   bus,
  input  logic                i_clr_cnt,
  output logic [CNT_BITS-1:0] o_err_cnt,
  output logic [CNT_BITS-1:0] o_ovf_cnt,
  output skid_state_t         o_dbg_state
);

  typedef struct packed {
    logic [BITS-1:0] result;
    arith_status_t   status;
  } entry_t;

  skid_state_t state_q, state_d;
  entry_t      head_q, head_d;
  entry_t      skid_q, skid_d;
  entry_t      in_entry;
  logic        ready_q, ready_d;
  logic        push, pop;

  assign push = bus.i_valid & ready_q;
  assign pop  = (state_q != EMPTY) & bus.i_ready;

  // Flags are decided here once and travel with the entry.
  always_comb begin
    in_entry.status = capture_status(bus.i_result[BITS-1], bus.i_result == '0,
                                     bus.i_overflow, bus.i_error);
    in_entry.result = bus.i_error ? '0 : bus.i_result;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = in_entry;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = FULL;
          skid_d  = in_entry;
        end else if (pop && !push) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          head_d = in_entry;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    ready_d = (state_d != FULL);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      ready_q <= 1'b0;
      head_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
    end
  end

  assign bus.o_ready    = ready_q;
  assign bus.o_valid    = (state_q != EMPTY);
  assign bus.o_result   = head_q.result;
  assign bus.o_error    = head_q.status.error;
  assign bus.o_overflow = head_q.status.overflow;
  assign bus.o_zero     = head_q.status.zero;
  assign bus.o_negative = head_q.status.negative;
  assign o_dbg_state    = state_q;

  // Overflow is only counted when it is not masked by an error.
  sat_counter #(.CNT_BITS(CNT_BITS)) u_err_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (push & bus.i_error),
    .i_clr   (i_clr_cnt),
    .o_cnt   (o_err_cnt)
  );

  sat_counter #(.CNT_BITS(CNT_BITS)) u_ovf_cnt (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (push & bus.i_overflow & ~bus.i_error),
    .i_clr   (i_clr_cnt),
    .o_cnt   (o_ovf_cnt)
  );

endmodule

// File: tb/tb_result_out_stage.sv
// Directed bench for result_out_stage with a 2-bit counter build so that
// saturation is reachable in a few pushes.
module tb_result_out_stage;
  import arith_pkg::*;

  localparam int BITS     = 32;
  localparam int CNT_BITS = 2;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                clr_cnt = 1'b0;
  logic [CNT_BITS-1:0] err_cnt;
  logic [CNT_BITS-1:0] ovf_cnt;
  skid_state_t         dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [BITS-1:0] exp_q[$];

  result_out_stage_if #(.BITS(BITS)) bus ();

  result_out_stage #(.BITS(BITS), .CNT_BITS(CNT_BITS)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .bus         (bus.slave),
    .i_clr_cnt   (clr_cnt),
    .o_err_cnt   (err_cnt),
    .o_ovf_cnt   (ovf_cnt),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_in(input logic v, input logic [BITS-1:0] r, input logic e, input logic o);
    bus.i_valid    = v;
    bus.i_result   = r;
    bus.i_error    = e;
    bus.i_overflow = o;
  endtask

  task automatic clear_counters();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
  endtask

  task automatic test_reset();
    drive_in(1'b0, '0, 1'b0, 1'b0);
    bus.i_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready: got %b want 0", bus.o_ready); end
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", bus.o_valid); end
    n_cmp++; if (bus.o_result !== 32'h0) begin n_err++; $display("FAIL rst_result: got %h want 0", bus.o_result); end
    n_cmp++; if ({bus.o_error, bus.o_overflow, bus.o_zero, bus.o_negative} !== 4'b0) begin n_err++; $display("FAIL rst_flags: got %b want 0000", {bus.o_error, bus.o_overflow, bus.o_zero, bus.o_negative}); end
    n_cmp++; if ({err_cnt, ovf_cnt} !== 4'b0) begin n_err++; $display("FAIL rst_cnt: got %h want 0", {err_cnt, ovf_cnt}); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL rel_ready_pre: got %b want 0", bus.o_ready); end
    step();
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL rel_ready_edge: got %b want 1", bus.o_ready); end
    n_cmp++; if (dbg_state !== EMPTY) begin n_err++; $display("FAIL rel_state: got %0d want EMPTY", dbg_state); end
  endtask

  task automatic test_capture();
    bus.i_ready = 1'b1;
    drive_in(1'b1, 32'h0000_00F0, 1'b0, 1'b0);
    step();
    drive_in(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (bus.o_valid !== 1'b1) begin n_err++; $display("FAIL cap_valid: got %b want 1", bus.o_valid); end
    n_cmp++; if (bus.o_result !== 32'h0000_00F0) begin n_err++; $display("FAIL cap_result: got %h want 000000f0", bus.o_result); end
    n_cmp++; if ({bus.o_zero, bus.o_negative} !== 2'b00) begin n_err++; $display("FAIL cap_flags: got %b want 00", {bus.o_zero, bus.o_negative}); end
    step();
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL cap_drain: got %b want 0", bus.o_valid); end
  endtask

  task automatic test_skid();
    clear_counters();
    bus.i_ready = 1'b0;
    drive_in(1'b1, 32'h8000_0000, 1'b0, 1'b0);
    step();
    n_cmp++; if (bus.o_ready !== 1'b1) begin n_err++; $display("FAIL skid_ready_one: got %b want 1", bus.o_ready); end
    drive_in(1'b1, 32'h0000_0001, 1'b0, 1'b0);
    step();
    n_cmp++; if (bus.o_ready !== 1'b0) begin n_err++; $display("FAIL skid_ready_full: got %b want 0", bus.o_ready); end
    n_cmp++; if (dbg_state !== FULL) begin n_err++; $display("FAIL skid_state: got %0d want FULL", dbg_state); end
    n_cmp++; if (bus.o_result !== 32'h8000_0000) begin n_err++; $display("FAIL skid_head: got %h want 80000000", bus.o_result); end
    n_cmp++; if (bus.o_negative !== 1'b1) begin n_err++; $display("FAIL skid_neg: got %b want 1", bus.o_negative); end
    // offered while full: must be ignored and not counted
    drive_in(1'b1, 32'h0000_0055, 1'b0, 1'b1);
    step();
    n_cmp++; if (bus.o_result !== 32'h8000_0000) begin n_err++; $display("FAIL skid_hold: got %h want 80000000", bus.o_result); end
    n_cmp++; if (ovf_cnt !== 2'd0) begin n_err++; $display("FAIL skid_ignored_cnt: got %0d want 0", ovf_cnt); end
    drive_in(1'b0, '0, 1'b0, 1'b0);
    bus.i_ready = 1'b1;
    step();
    n_cmp++; if (bus.o_result !== 32'h0000_0001) begin n_err++; $display("FAIL skid_second: got %h want 00000001", bus.o_result); end
    n_cmp++; if ({bus.o_ready, bus.o_negative} !== 2'b10) begin n_err++; $display("FAIL skid_after_pop: got %b want 10", {bus.o_ready, bus.o_negative}); end
    step();
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL skid_drain: got %b want 0", bus.o_valid); end
  endtask

  task automatic test_error();
    clear_counters();
    bus.i_ready = 1'b0;
    drive_in(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    step();
    drive_in(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (bus.o_result !== 32'h0) begin n_err++; $display("FAIL err_result: got %h want 0", bus.o_result); end
    n_cmp++; if ({bus.o_error, bus.o_overflow, bus.o_zero, bus.o_negative} !== 4'b1000) begin n_err++; $display("FAIL err_flags: got %b want 1000", {bus.o_error, bus.o_overflow, bus.o_zero, bus.o_negative}); end
    n_cmp++; if (err_cnt !== 2'd1) begin n_err++; $display("FAIL err_errcnt: got %0d want 1", err_cnt); end
    n_cmp++; if (ovf_cnt !== 2'd0) begin n_err++; $display("FAIL err_ovfcnt: got %0d want 0", ovf_cnt); end
    bus.i_ready = 1'b1;
    step();
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL err_drain: got %b want 0", bus.o_valid); end
  endtask

  task automatic test_saturate();
    logic [CNT_BITS-1:0] exp_c;
    clear_counters();
    bus.i_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      drive_in(1'b1, BITS'(k), 1'b0, 1'b1);
      step();
      exp_c = (k > 3) ? 2'd3 : CNT_BITS'(k);
      n_cmp++; if (ovf_cnt !== exp_c) begin n_err++; $display("FAIL sat_cnt[%0d]: got %0d want %0d", k, ovf_cnt, exp_c); end
      n_cmp++; if ({bus.o_result, bus.o_overflow} !== {BITS'(k), 1'b1}) begin n_err++; $display("FAIL sat_data[%0d]: got %h/%b want %h/1", k, bus.o_result, bus.o_overflow, k); end
    end
    drive_in(1'b1, 32'h0000_0006, 1'b0, 1'b1);
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    drive_in(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if (ovf_cnt !== 2'd0) begin n_err++; $display("FAIL sat_clr: got %0d want 0", ovf_cnt); end
    n_cmp++; if (bus.o_result !== 32'h0000_0006) begin n_err++; $display("FAIL sat_clr_data: got %h want 00000006", bus.o_result); end
    step();
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL sat_drain: got %b want 0", bus.o_valid); end
  endtask

  task automatic test_back_to_back();
    logic [BITS-1:0] exp_v;
    bus.i_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive_in(1'b1, BITS'(k), 1'b0, 1'b0);
      exp_q.push_back(BITS'(k));
      step();
      exp_v = exp_q.pop_front();
      n_cmp++; if ({bus.o_valid, bus.o_ready} !== 2'b11) begin n_err++; $display("FAIL b2b_hs[%0d]: got %b want 11", k, {bus.o_valid, bus.o_ready}); end
      n_cmp++; if (bus.o_result !== exp_v) begin n_err++; $display("FAIL b2b_data[%0d]: got %h want %h", k, bus.o_result, exp_v); end
      n_cmp++; if (bus.o_zero !== (k == 0)) begin n_err++; $display("FAIL b2b_zero[%0d]: got %b want %b", k, bus.o_zero, k == 0); end
    end
    drive_in(1'b0, '0, 1'b0, 1'b0);
    step();
    n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b want 0", bus.o_valid); end
  endtask

  task automatic test_reset_mid();
    bus.i_ready = 1'b0;
    drive_in(1'b1, 32'h0000_0AAA, 1'b0, 1'b1);
    step();
    drive_in(1'b1, 32'h0000_0BBB, 1'b0, 1'b1);
    step();
    drive_in(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if ({dbg_state, ovf_cnt} !== {FULL, 2'd2}) begin n_err++; $display("FAIL mid_pre: got %0d/%0d want FULL/2", dbg_state, ovf_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({bus.o_valid, bus.o_ready} !== 2'b00) begin n_err++; $display("FAIL mid_rst_hs: got %b want 00", {bus.o_valid, bus.o_ready}); end
    n_cmp++; if ({bus.o_result, ovf_cnt} !== {32'h0, 2'd0}) begin n_err++; $display("FAIL mid_rst_state: got %h/%0d want 0/0", bus.o_result, ovf_cnt); end
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if ({bus.o_ready, bus.o_valid} !== 2'b10) begin n_err++; $display("FAIL mid_rel: got %b want 10", {bus.o_ready, bus.o_valid}); end
    bus.i_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      step();
      n_cmp++; if (bus.o_valid !== 1'b0) begin n_err++; $display("FAIL mid_stale[%0d]: got %b want 0", k, bus.o_valid); end
    end
    drive_in(1'b1, 32'h0000_1234, 1'b0, 1'b0);
    step();
    drive_in(1'b0, '0, 1'b0, 1'b0);
    n_cmp++; if ({bus.o_valid, bus.o_result} !== {1'b1, 32'h0000_1234}) begin n_err++; $display("FAIL mid_fresh: got %b/%h want 1/00001234", bus.o_valid, bus.o_result); end
    step();
  endtask

  initial begin
    test_reset();
    test_capture();
    test_skid();
    test_error();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
